// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings,
// buffer occupancy states, default widths and the buffered entry layout.
package imm_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_BR_W      = 9;
  localparam int DEF_MEM_W     = 4;
  localparam int DEF_IMM_W     = 8;
  localparam int DEF_MEM_SHIFT = 0;
  localparam int DEF_ERR_CNT_W = 8;
  localparam int MODE_W        = 3;

  // Extension modes; encodings 5..7 are illegal.
  typedef enum logic [MODE_W-1:0] {
    IMM_BR  = 3'd0,
    IMM_MEM = 3'd1,
    IMM_IMM = 3'd2,
    IMM_LLB = 3'd3,
    IMM_LHB = 3'd4
  } imm_mode_e;

  // Occupancy of the main/skid register pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // Buffered entry at default widths. The pipeline declares the same layout
  // locally so it follows a non-default DATA_W.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] imm;
    logic [MODE_W-1:0]     mode;
    logic                  err;
    logic [DEF_DATA_W-1:0] target;
  } imm_entry_t;

  // True for the five defined extension modes.
  function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
    return (m <= MODE_W'(IMM_LHB));
  endfunction

endpackage

// File: rtl/imm_ext_comb.sv
// Purely combinational immediate extension for one instruction/mode pair.
// Optional branch-target adder enabled by defining IMM_BRTARGET_EN.
module imm_ext_comb
  import imm_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BR_W      = DEF_BR_W,
  parameter int MEM_W     = DEF_MEM_W,
  parameter int IMM_W     = DEF_IMM_W,
  parameter int MEM_SHIFT = DEF_MEM_SHIFT
) (
  input  logic [DATA_W-1:0] instr,
  input  logic [MODE_W-1:0] mode,
  input  logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] imm,
  output logic              err,
  output logic [DATA_W-1:0] target
);

  logic [DATA_W-1:0] br_ext;
  logic [DATA_W-1:0] mem_ext;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] llb_ext;
  logic [DATA_W-1:0] lhb_ext;
  logic              unused_instr;

  // Extend to the full width first, then shift; bits shifted past DATA_W drop.
  assign br_ext  = DATA_W'(signed'(instr[BR_W-1:0])) << 1;
  assign mem_ext = DATA_W'(signed'(instr[MEM_W-1:0])) << MEM_SHIFT;
  assign imm_ext = DATA_W'(signed'(instr[IMM_W-1:0]));
  assign llb_ext = DATA_W'(instr[7:0]);
  assign lhb_ext = DATA_W'({instr[7:0], 8'h00});

  // Upper instruction bits only matter to the decoder, not to extension.
  assign unused_instr = ^instr;

  // Select the extension for the mode; illegal modes give zero and flag err.
  always_comb begin
    imm = '0;
    err = 1'b0;
    case (mode)
      IMM_BR:  imm = br_ext;
      IMM_MEM: imm = mem_ext;
      IMM_IMM: imm = imm_ext;
      IMM_LLB: imm = llb_ext;
      IMM_LHB: imm = lhb_ext;
      default: err = 1'b1;
    endcase
  end

`ifdef IMM_BRTARGET_EN
  // Branch target is PC+2 plus the scaled offset, wrapping at DATA_W.
  assign target = (mode == IMM_BR) ? (pc + br_ext) : '0;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign target    = '0;
`endif

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a two-entry skid buffer.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid must not depend on ready, and a presented output entry holds its
// payload stable until it is taken.
// Optional branch-target adder enabled by defining IMM_BRTARGET_EN.
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BR_W      = DEF_BR_W,
  parameter int MEM_W     = DEF_MEM_W,
  parameter int IMM_W     = DEF_IMM_W,
  parameter int MEM_SHIFT = DEF_MEM_SHIFT,
  parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_instr,
  input  logic [MODE_W-1:0]    in_mode,
  input  logic [DATA_W-1:0]    in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_imm,
  output logic [MODE_W-1:0]    out_mode,
  output logic                 out_err,
  output logic [DATA_W-1:0]    out_target,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output buf_state_e           dbg_state
);

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [MODE_W-1:0] mode;
    logic              err;
    logic [DATA_W-1:0] target;
  } entry_t;

  buf_state_e            state_q;
  buf_state_e            state_d;
  entry_t                in_entry;
  entry_t                main_q;
  entry_t                skid_q;
  logic                  in_ready_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [DATA_W-1:0]     ext_imm;
  logic                  ext_err;
  logic [DATA_W-1:0]     ext_target;
  logic                  accept;
  logic                  drain;
  logic                  load_new;
  logic                  load_skid;
  logic                  skid_to_main;

  imm_ext_comb #(
    .DATA_W    (DATA_W),
    .BR_W      (BR_W),
    .MEM_W     (MEM_W),
    .IMM_W     (IMM_W),
    .MEM_SHIFT (MEM_SHIFT)
  ) u_ext (
    .instr  (in_instr),
    .mode   (in_mode),
    .pc     (in_pc),
    .imm    (ext_imm),
    .err    (ext_err),
    .target (ext_target)
  );

  assign in_entry = {ext_imm, in_mode, ext_err, ext_target};

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid && out_ready;

  // Occupancy transitions and which register loads what this cycle.
  always_comb begin
    state_d      = state_q;
    load_new     = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d  = ST_ONE;
          load_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          load_new = 1'b1;
        end else if (accept) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          state_d      = ST_ONE;
          skid_to_main = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush empties the buffer; payload registers keep their last values.
    if (flush) begin
      state_d      = ST_EMPTY;
      load_new     = 1'b0;
      load_skid    = 1'b0;
      skid_to_main = 1'b0;
    end
  end

  // Occupancy state and the registered ready (low exactly while FULL).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Main (output) register: takes the new entry or the older skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
    end else if (skid_to_main) begin
      main_q <= skid_q;
    end else if (load_new) begin
      main_q <= in_entry;
    end
  end

  // Skid register: holds the entry that arrived while main was stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '0;
    end else if (load_skid) begin
      skid_q <= in_entry;
    end
  end

  // Saturating count of accepted illegal modes; flush does not clear it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (accept && ext_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (state_q != ST_EMPTY);
  assign out_imm    = main_q.imm;
  assign out_mode   = main_q.mode;
  assign out_err    = main_q.err;
  assign out_target = main_q.target;
  assign err_cnt    = err_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed + random bench for imm_ext_pipe at default parameters.
module tb_imm_ext_pipe;
  import imm_pkg::*;

  localparam int EW = 36;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  in_mode;
  logic [15:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [2:0]  out_mode;
  logic        out_err;
  logic [15:0] out_target;
  logic [7:0]  err_cnt;
  buf_state_e  dbg_state;

  logic [EW-1:0] exp_q[$];
  int          checks;
  int          failures;
  int          err_model;

  imm_ext_pipe dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_mode    (in_mode),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_mode   (out_mode),
    .out_err    (out_err),
    .out_target (out_target),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension at default widths: {imm, mode, err, target}
  function automatic logic [EW-1:0] model(input logic [15:0] i, input logic [2:0] m,
                                          input logic [15:0] pc);
    logic [15:0] v;
    logic        e;
    logic [15:0] t;
    v = 16'h0000;
    e = 1'b0;
    t = 16'h0000;
    case (m)
      3'd0:    v = {{6{i[8]}}, i[8:0], 1'b0};
      3'd1:    v = {{12{i[3]}}, i[3:0]};
      3'd2:    v = {{8{i[7]}}, i[7:0]};
      3'd3:    v = {8'h00, i[7:0]};
      3'd4:    v = {i[7:0], 8'h00};
      default: e = 1'b1;
    endcase
`ifdef IMM_BRTARGET_EN
    if (m == 3'd0) t = pc + v;
`else
    t = 16'h0000 & pc;
`endif
    return {v, m, e, t};
  endfunction

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [2:0] m,
                       input logic [15:0] pc);
    in_valid = v;
    in_instr = i;
    in_mode  = m;
    in_pc    = pc;
  endtask

  // Pop the oldest expected entry and compare it with the presented output.
  task automatic pop_and_check();
    logic [EW-1:0] e;
    if (exp_q.size() == 0) begin
      chk("unexpected_output", {35'd0, out_valid}, '0);
    end else begin
      e = exp_q.pop_front();
      chk("out_imm", EW'(out_imm), EW'(e[35:20]));
      chk("out_mode", EW'(out_mode), EW'(e[19:17]));
      chk("out_err", EW'(out_err), EW'(e[16]));
      chk("out_target", EW'(out_target), EW'(e[15:0]));
    end
  endtask

  // One clock: sample handshakes at the negedge, update scoreboard, advance.
  task automatic step(output bit acc);
    bit drn;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) pop_and_check();
    if (acc) begin
      if (in_mode >= 3'd5 && err_model < 255) err_model++;
      if (!flush) exp_q.push_back(model(in_instr, in_mode, in_pc));
    end
    @(posedge clk);
    if (flush) exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int budget;
    int n_acc;
    checks    = 0;
    failures  = 0;
    err_model = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'h0000, 3'd0, 16'h0000);

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", EW'(out_valid), EW'(0));
    chk("rst_in_ready", EW'(in_ready), EW'(1));
    chk("rst_out_imm", EW'(out_imm), EW'(0));
    chk("rst_out_mode", EW'(out_mode), EW'(0));
    chk("rst_out_err", EW'(out_err), EW'(0));
    chk("rst_out_target", EW'(out_target), EW'(0));
    chk("rst_err_cnt", EW'(err_cnt), EW'(0));
    chk("rst_state", EW'(dbg_state), EW'(ST_EMPTY));
    rst = 1'b0;
    @(negedge clk);

    // BR mode, one-cycle latency, explicit expected constants
    out_ready = 1'b1;
    drive(1'b1, 16'h01FF, 3'd0, 16'h0010);
    step(acc);
    drive(1'b0, 16'h0000, 3'd0, 16'h0000);
    chk("br_latency_valid", EW'(out_valid), EW'(1));
    chk("br_imm_const", EW'(out_imm), EW'(16'hFFFE));
    chk("br_err_const", EW'(out_err), EW'(0));
`ifdef IMM_BRTARGET_EN
    chk("br_target_const", EW'(out_target), EW'(16'h000E));
`else
    chk("br_target_const", EW'(out_target), EW'(16'h0000));
`endif
    step(acc);

    // Modes 1..4 back to back
    for (int m = 1; m <= 4; m++) begin
      drive(1'b1, 16'h00F8, 3'(m), 16'h0100);
      step(acc);
    end
    drive(1'b0, 16'h0000, 3'd0, 16'h0000);
    step(acc);
    chk("modes_drained", EW'(exp_q.size()), EW'(0));

    // Three entries with out_ready low, then release: order, no gaps
    out_ready = 1'b0;
    drive(1'b1, 16'h0123, 3'd2, 16'h0000);
    step(acc);
    drive(1'b1, 16'h0045, 3'd3, 16'h0000);
    step(acc);
    chk("full_in_ready", EW'(in_ready), EW'(0));
    chk("full_state", EW'(dbg_state), EW'(ST_FULL));
    drive(1'b1, 16'h0067, 3'd4, 16'h0000);
    step(acc);
    chk("full_no_accept", EW'(acc), EW'(0));
    out_ready = 1'b1;
    budget = 10;
    while (budget > 0 && (in_valid || exp_q.size() > 0)) begin
      chk("no_gap", EW'(out_valid), EW'(1));
      step(acc);
      if (acc) in_valid = 1'b0;
      budget--;
    end
    chk("release_budget", EW'(exp_q.size()), EW'(0));

    // Flush in FULL with in_valid high
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 3'd1, 16'h0000);
    step(acc);
    drive(1'b1, 16'h0022, 3'd2, 16'h0000);
    step(acc);
    drive(1'b1, 16'h0033, 3'd7, 16'h0000);
    flush = 1'b1;
    step(acc);
    flush = 1'b0;
    drive(1'b0, 16'h0000, 3'd0, 16'h0000);
    chk("flush_full_valid", EW'(out_valid), EW'(0));
    chk("flush_full_ready", EW'(in_ready), EW'(1));
    chk("flush_full_state", EW'(dbg_state), EW'(ST_EMPTY));

    // Flush in ONE with a simultaneous illegal accept: dropped but counted
    drive(1'b1, 16'h0044, 3'd3, 16'h0000);
    step(acc);
    drive(1'b1, 16'h0055, 3'd5, 16'h0000);
    flush = 1'b1;
    step(acc);
    flush = 1'b0;
    drive(1'b0, 16'h0000, 3'd0, 16'h0000);
    chk("flush_one_valid", EW'(out_valid), EW'(0));
    chk("flush_err_cnt", EW'(err_cnt), EW'(err_model));
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("flush_idle_valid", EW'(out_valid), EW'(0));
      step(acc);
    end

    // 300 illegal-mode accepts: err flagged, imm zero, counter saturates
    n_acc  = 0;
    budget = 400;
    while (n_acc < 300 && budget > 0) begin
      drive(1'b1, 16'($urandom_range(0, 65535)), 3'd6, 16'($urandom_range(0, 65535)));
      step(acc);
      if (acc) n_acc++;
      budget--;
    end
    drive(1'b0, 16'h0000, 3'd0, 16'h0000);
    chk("err_accepts", EW'(n_acc), EW'(300));
    step(acc);
    chk("err_drained", EW'(exp_q.size()), EW'(0));
    chk("err_cnt_sat", EW'(err_cnt), EW'(err_model));
    chk("err_cnt_255", EW'(err_cnt), EW'(255));

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 16'h0101, 3'd0, 16'h0000);
    step(acc);
    drive(1'b1, 16'h0202, 3'd1, 16'h0000);
    step(acc);
    drive(1'b0, 16'h0000, 3'd0, 16'h0000);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", EW'(out_valid), EW'(0));
    chk("async_rst_ready", EW'(in_ready), EW'(1));
    chk("async_rst_err_cnt", EW'(err_cnt), EW'(0));
    exp_q.delete();
    err_model = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random traffic with random backpressure
    for (int k = 0; k < 80; k++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
            3'($urandom_range(0, 7)), 16'($urandom_range(0, 65535)));
      out_ready = 1'($urandom_range(0, 1));
      step(acc);
    end
    drive(1'b0, 16'h0000, 3'd0, 16'h0000);
    out_ready = 1'b1;
    budget = 10;
    while (budget > 0 && exp_q.size() > 0) begin
      step(acc);
      budget--;
    end
    chk("random_drained", EW'(exp_q.size()), EW'(0));
    chk("random_err_cnt", EW'(err_cnt), EW'(err_model));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

- Parametrised, registered immediate-extension stage between instruction decode and the ID/EX boundary.
- Accepts an instruction word plus an extension mode over a valid/ready handshake and produces the extended immediate one cycle later.
- A two-entry skid buffer lets decode stall without bubbles; a flush input discards in-flight entries.
- Adds LHB placement, illegal-mode flagging with a saturating error counter, and an optional branch-target adder.

## Interface
- DATA_W, 16, instruction/immediate/PC width
- BR_W, 9, branch offset field width (bits [BR_W-1:0])
- MEM_W, 4, memory offset field width (bits [MEM_W-1:0])
- IMM_W, 8, arithmetic immediate field width (bits [IMM_W-1:0])
- MEM_SHIFT, 0, left shift applied to the memory offset after extension
- ERR_CNT_W, 8, error counter width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard all buffered entries
- in_valid  in  1  input entry present
- in_ready  out  1  stage can accept
- in_instr  in  DATA_W  instruction word
- in_mode  in  3  extension mode
- in_pc  in  DATA_W  PC+2 of the instruction; used only with the target adder
- out_valid  out  1  output entry present
- out_ready  in  1  consumer accepts
- out_imm  out  DATA_W  extended immediate
- out_mode  out  3  mode of the output entry
- out_err  out  1  output entry had an illegal mode
- out_target  out  DATA_W  branch target (see Configuration)
- err_cnt  out  ERR_CNT_W  saturating count of illegal modes accepted

## Operation
- Modes:
  - 0 BR: sign-extend [BR_W-1:0], then <<1.
  - 1 MEM: sign-extend [MEM_W-1:0], then <<MEM_SHIFT.
  - 2 IMM: sign-extend [IMM_W-1:0].
  - 3 LLB: zero-extend [7:0].
  - 4 LHB: {[7:0], 8'h00}, zero above bit 15 when DATA_W>16.
  - 5–7: illegal; out_imm=0, out_err=1.
- Arithmetic: extension to DATA_W before shifting; shifted bits beyond DATA_W are dropped. Requires DATA_W ≥ max(BR_W+1, MEM_W+MEM_SHIFT, IMM_W, 16).
- Buffering: output register (main) plus one skid register. in_ready = !skid_valid, driven from a flop.
- Accept on in_valid && in_ready.
- Main loads the computed entry when empty or when being drained (out_ready). Otherwise the entry goes to skid.
- When main drains and skid is full, skid moves into main.
- States: EMPTY (0 entries), ONE (main only), FULL (main+skid).
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without drain.
  - ONE→EMPTY on drain without accept.
  - FULL→ONE on drain; no accept is possible in FULL.
- Entries leave in strict acceptance order.
- err_cnt increments on each accepted illegal-mode entry, saturates at all-ones, and is not cleared by flush.
- flush: next edge empties both registers. A simultaneous accept is dropped, but an accepted illegal mode still counts. A simultaneous drain counts as completed for the consumer.

## Timing
- Latency: accept at edge N → out_valid high after edge N, data stable until out_valid && out_ready.
- Throughput: one entry per cycle while out_ready=1.
- in_ready falls the cycle after FULL is entered and rises the cycle after the first drain from FULL.
- Reset values: out_valid=0, in_ready=1, out_imm=0, out_mode=0, out_err=0, out_target=0, err_cnt=0, state EMPTY.
- Reset mid-transfer discards all entries immediately (asynchronously).
- out_* payload is undefined-free: holds the last value while out_valid=0.

## Configuration
- IMM_BRTARGET_EN defined: out_target = in_pc + BR immediate, modulo 2^DATA_W. It is computed at acceptance and buffered with the entry; for non-BR modes out_target=0.
- Not defined: no adder, in_pc ignored, out_target tied to 0.

## Structure
- Shared package imm_pkg:
  - mode encodings IMM_BR, IMM_MEM, IMM_IMM, IMM_LLB, IMM_LHB;
  - entry struct {imm, mode, err, target};
  - default widths.
- Sub-module imm_ext_comb: purely combinational extension for one instruction/mode, instantiated once at the input.

## Test plan
- Default params, mode 0, instr 16'h01FF, out_ready=1 → one cycle later out_imm=16'hFFFE, out_err=0; with IMM_BRTARGET_EN and in_pc=16'h0010, out_target=16'h000E.
- Modes 1/2/3/4 with instr 16'h00F8 → out_imm=16'hFFF8 / 16'hFFF8 / 16'h00F8 / 16'hF800 (MEM_SHIFT=0).
- Back-to-back 3 entries with out_ready=0 → in_ready low after the second accept. Releasing out_ready yields all three in order with no gaps.
- Mode 6 accepted 300 times with ERR_CNT_W=8 → every output has out_err=1, out_imm=0; err_cnt=255.
- FULL state, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed input is never output.
- rst asserted mid-stream with out_ready=0 → out_valid=0 and in_ready=1 immediately, before the next clock edge.
